// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as
// two halfword cycles plus fixed wait padding; ready low freezes the pipeline.
module sram_mem_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int unsigned IDX_W    = SRAM_AW - 1;
  localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WAIT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [15:0]      lo_buf_q, lo_buf_d;
  logic [31:0]      rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      lo_buf_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      lo_buf_q <= lo_buf_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    lo_buf_d = lo_buf_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (rd_en || wr_en) begin
          // Write wins when both requests are raised together.
          is_wr_d = wr_en;
          idx_d   = IDX_W'((address - BASE_ADDR) >> 2);
          wdata_d = writeData;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (!is_wr_q) lo_buf_d = sram_dq_in;
        state_d = S_HI;
      end
      S_HI: begin
        if (!is_wr_q) rdata_d = {sram_dq_in, lo_buf_q};
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_q)
      S_LO: begin
        sram_addr = {idx_q, 1'b0};
        if (is_wr_q) begin
          sram_dq_out = wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      S_HI: begin
        sram_addr = {idx_q, 1'b1};
        if (is_wr_q) begin
          sram_dq_out = wdata_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      S_WAIT, S_DONE: sram_addr = {idx_q, 1'b1};
      default: ;
    endcase
    ready    = ((state_q == S_IDLE) && !rd_en && !wr_en) || (state_q == S_DONE);
    readData = rdata_q;
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: word/halfword reference memory plus a
// cycle-offset timing model, compared against the DUT pins every cycle.
module tb_sram_mem_controller;

  localparam int unsigned W = 3;
  localparam int unsigned T = 3 + W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, writeData = '0;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        rd2 = 1'b0, wr2 = 1'b0;
  logic [31:0] addr2 = '0, wd2 = '0;
  logic [31:0] readData2;
  logic        ready2;
  logic [17:0] sram_addr2;
  logic [15:0] dq_out2, dq_in2;
  logic        dq_oe2, we_n2;

  int errors = 0;
  int checks = 0;

  logic [15:0] sram    [0:262143] = '{default: '0};
  logic [15:0] ref_mem [0:262143] = '{default: '0};

  always #5 clk = ~clk;

  sram_mem_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W), .SRAM_AW(18)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  sram_mem_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .SRAM_AW(18)) u_dut_w1 (
    .clk(clk), .rst(rst), .rd_en(rd2), .wr_en(wr2), .address(addr2),
    .writeData(wd2), .readData(readData2), .ready(ready2),
    .sram_addr(sram_addr2), .sram_dq_out(dq_out2), .sram_dq_in(dq_in2),
    .sram_dq_oe(dq_oe2), .sram_we_n(we_n2)
  );

  // Asynchronous SRAM: combinational read, write captured on the clock.
  assign sram_dq_in = sram[sram_addr];
  assign dq_in2     = sram_addr2[15:0];

  always @(posedge clk) begin
    if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access = request cycle k=0, low half k=1, high half k=2,
  // ready at k=T; everything derived from the cycle offset since the request.
  initial begin : model
    bit          busy;
    int unsigned k, m_idx, e_addr;
    bit          m_wr, e_we_n, e_oe, e_rdy;
    logic [31:0] m_wd, exp_rd;
    logic [15:0] e_dq;
    busy = 0; k = 0; m_idx = 0; m_wr = 0; m_wd = '0; exp_rd = '0;
    forever begin
      @(negedge clk);
      e_addr = 0; e_we_n = 1; e_oe = 0; e_dq = '0; e_rdy = 0;
      if (!rst) begin
        busy = 0; k = 0; exp_rd = '0;
      end else if (!busy) begin
        e_rdy = !(rd_en || wr_en);
      end else begin
        e_addr = m_idx * 2 + ((k == 1) ? 0 : 1);
        if (m_wr && k <= 2) begin
          e_we_n = 0;
          e_oe   = 1;
          e_dq   = (k == 1) ? m_wd[15:0] : m_wd[31:16];
        end
        e_rdy = (k == T);
      end
      chk("ready",       32'(ready),       32'(e_rdy));
      chk("sram_addr",   32'(sram_addr),   e_addr);
      chk("sram_we_n",   32'(sram_we_n),   32'(e_we_n));
      chk("sram_dq_oe",  32'(sram_dq_oe),  32'(e_oe));
      chk("sram_dq_out", 32'(sram_dq_out), 32'(e_dq));
      chk("readData",    readData,         exp_rd);
      if (rst) begin
        if (!busy) begin
          if (rd_en || wr_en) begin
            busy  = 1;
            k     = 1;
            m_wr  = wr_en;
            m_idx = ((address - 32'd1024) >> 2) & 32'h1FFFF;
            m_wd  = writeData;
          end
        end else begin
          if (k == 1 && m_wr) ref_mem[m_idx * 2] = m_wd[15:0];
          if (k == 2) begin
            if (m_wr) ref_mem[m_idx * 2 + 1] = m_wd[31:16];
            else      exp_rd = {ref_mem[m_idx * 2 + 1], ref_mem[m_idx * 2]};
          end
          if (k == T) busy = 0;
          else        k = k + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0;
    wr_en = 1'b0;
    repeat (n) tick();
  endtask

  // mode 0: hold request; 1: random noise on inputs after cycle 0;
  // 2: drop the request at the start of the high-half cycle.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input int mode, output int lat);
    rd_en = rd; wr_en = wr; address = a; writeData = d;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c;
        break;
      end
      tick();
      if (mode == 1) begin
        rd_en = 1'($urandom); wr_en = 1'($urandom);
        address = $urandom; writeData = $urandom;
      end else if (mode == 2 && c == 1) begin
        rd_en = 1'b0; wr_en = 1'b0;
      end
    end
    chk("latency", 32'(lat), 32'(T));
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int          lat;
    int unsigned op;
    logic [31:0] a, d;

    #1;
    rst = 1'b0; rd_en = 1'b1; address = 32'd1024;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_ready",    32'(ready),     32'd0);
    chk("reset_readData", readData,       32'd0);
    chk("reset_we_n",     32'(sram_we_n), 32'd1);
    tick();
    rst = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);
    tick();

    access(1, 0, 32'd1032, 32'hDEADBEEF, 0, lat);
    chk("wr_sram_lo", 32'(sram[4]), 32'h0000BEEF);
    chk("wr_sram_hi", 32'(sram[5]), 32'h0000DEAD);
    access(0, 1, 32'd1032, 32'h0, 0, lat);
    chk("rd_word", readData, 32'hDEADBEEF);

    access(1, 1, 32'd1024, 32'h12345678, 0, lat);
    chk("both_lo",       32'(sram[0]), 32'h00005678);
    chk("both_hi",       32'(sram[1]), 32'h00001234);
    chk("both_readData", readData,     32'hDEADBEEF);

    access(1, 0, 32'd1028, 32'h0BADF00D, 0, lat);
    access(0, 1, 32'd1028, 32'h0, 2, lat);
    chk("drop_readData", readData, 32'h0BADF00D);
    idle(2);

    access(1, 0, 32'd1040, 32'h11112222, 0, lat);
    wr_en = 1'b1; address = 32'd1040; writeData = 32'hAAAABBBB;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hi_we_n", 32'(sram_we_n),  32'd1);
    chk("rst_hi_oe",   32'(sram_dq_oe), 32'd0);
    tick();
    wr_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(ready), 32'd1);
    tick();
    access(0, 1, 32'd1040, 32'h0, 0, lat);
    chk("partial_write", readData, 32'h1111BBBB);

    access(1, 0, 32'd525308, 32'hCAFEF00D, 0, lat);
    chk("top_lo", 32'(sram[18'h3FFFE]), 32'h0000F00D);
    chk("top_hi", 32'(sram[18'h3FFFF]), 32'h0000CAFE);
    access(0, 1, 32'd1020, 32'h0, 0, lat);
    chk("wrap_read", readData, 32'hCAFEF00D);

    for (int i = 0; i < 60; i++) begin
      idle(int'($urandom_range(0, 2)));
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) a = 32'd1024 - 4 * $urandom_range(1, 4);
      else                           a = 32'd1024 + 4 * $urandom_range(0, 15);
      a = a + 32'($urandom_range(0, 3));
      d = $urandom;
      access(op != 0, op != 1, a, d, int'($urandom_range(0, 1)), lat);
    end
    idle(2);

    rd2 = 1'b1; addr2 = 32'd1036;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready2) begin
        lat = c;
        break;
      end
      tick();
    end
    chk("w1_latency", 32'(lat), 32'd4);
    tick();
    rd2 = 1'b0;
    chk("w1_readData", readData2, 32'h00070006);
    @(negedge clk);
    chk("w1_idle_ready", 32'(ready2), 32'd1);
    tick();

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences every MEM-stage load/store onto the external 16-bit asynchronous SRAM.
- Splits each 32-bit word access into a low-halfword and a high-halfword SRAM cycle, then pads to a fixed access time.
- Drives ready, which the pipeline uses as a freeze: IF/ID/EXE/MEM registers hold while ready=0.
- Sits between the MEM-stage control signals (MEM_R_EN/MEM_W_EN, ALU address, Val_Rm store data) and the SRAM pins.

Parameters:
BASE_ADDR, 1024, byte address that maps to SRAM halfword 0
WAIT_CYCLES, 3, idle padding cycles after the two halfword cycles (legal range 1..15)
SRAM_AW, 18, SRAM halfword address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rd_en  in  1  load request (MEM_R_EN)
wr_en  in  1  store request (MEM_W_EN)
address  in  32  byte address from ALU
writeData  in  32  store data
readData  out  32  load result, registered
ready  out  1  access complete / no access pending; pipeline freeze = ~ready
sram_addr  out  SRAM_AW  SRAM halfword address
sram_dq_out  out  16  data to SRAM
sram_dq_in  in  16  data from SRAM
sram_dq_oe  out  1  1 = controller drives DQ
sram_we_n  out  1  SRAM write strobe, active-low

Behaviour:
- FSM states: IDLE, LO, HI, WAIT, DONE. State plus counter cnt[3:0].
- Reset (rst=0, async, any state):
  - state=IDLE, cnt=0, readData=0.
  - Latched op/address/data cleared to 0.
  - An in-flight access is abandoned; no partial-write recovery.
- IDLE:
  - If wr_en|rd_en: latch op (write if wr_en, regardless of rd_en), word index, and writeData; go to LO.
  - Else stay in IDLE.
- Word index = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - Bits [1:0] of address are ignored.
  - Addresses below BASE_ADDR wrap modulo 2^(SRAM_AW-1).
- LO:
  - sram_addr = {idx, 1'b0}.
  - Write: sram_dq_out = wdata[15:0], oe=1, we_n=0.
  - Read: we_n=1, oe=0, lo_buf <= sram_dq_in at end of cycle.
  - Next state HI.
- HI:
  - sram_addr = {idx, 1'b1}.
  - Write: dq_out = wdata[31:16], oe=1, we_n=0.
  - Read: readData <= {sram_dq_in, lo_buf} at end of cycle.
  - Next state WAIT, cnt=0.
- WAIT:
  - we_n=1, oe=0, sram_addr holds {idx,1'b1}.
  - cnt increments each cycle; leave for DONE when cnt==WAIT_CYCLES-1.
- DONE: outputs as WAIT; unconditional next state IDLE.
- ready (combinational) = (state==IDLE & ~rd_en & ~wr_en) | (state==DONE).
- Latency: request seen in IDLE in cycle 0 gives ready=1 in cycle 3+WAIT_CYCLES (default cycle 6). Pipeline advances on that edge.
- readData:
  - Changes only at the end of HI for a read.
  - Holds through WAIT/DONE and afterwards until the next read.
  - Writes never change it.
- Request inputs are ignored outside IDLE. Deassertion or change mid-access has no effect; the latched op completes.
- Back-to-back requests: DONE→IDLE costs one cycle with ready=0 before the next LO. The MEM register presents the new request in that IDLE cycle.
- Outside LO/HI-write: sram_we_n=1 and sram_dq_oe=0. sram_dq_out=0 when oe=0.
- In IDLE, sram_addr=0.

Test Plan:
1. Reset:
   - Hold rst=0 with rd_en=1 → ready=0, readData=0, we_n=1, oe=0.
   - Release with rd_en=wr_en=0 → ready=1, state IDLE.
2. Write then read:
   - Stimulus: wr_en=1, address=1024+8, writeData=0xDEADBEEF.
   - Write response: LO addr=4 with dq_out=0xBEEF, we_n=0; HI addr=5 with dq_out=0xDEAD; ready=1 exactly in cycle 6.
   - Then rd_en=1 at the same address, SRAM model returning stored data → readData=0xDEADBEEF at end of HI, ready in cycle 6.
3. Simultaneous requests:
   - rd_en=wr_en=1, address=1024, writeData=0x12345678 → treated as write.
   - SRAM halfwords 0/1 = 0x5678/0x1234; readData unchanged.
4. Request dropped mid-access:
   - Start read at 1024+4; deassert rd_en during HI → access still completes.
   - readData = stored word; ready pulses in cycle 6.
   - No new access starts in the following IDLE.
5. Reset mid-write:
   - Assert rst=0 during HI of a write → same cycle we_n=1, oe=0; after release ready=1.
   - Next read of that address returns the new low half and the old high half.
6. Address wrap and parameter:
   - address=1024+4*(2^17-1) → sram_addr 0x3FFFE/0x3FFFF.
   - address=1020 → idx 0x1FFFF.
   - With WAIT_CYCLES=1, ready in cycle 4.
